conv_window_scanner: RTL and testbench
======================================

CONV_WINDOW_SCANNER -- requirements
Module: conv_window_scanner

Interface
REQ-001 Parameter FEATURE_BITWIDTH, default `FEATURE_BITWIDTH (8): bits per feature element.
REQ-002 Parameter IMAGE_WIDTH, default `IMAGE_WIDTH (28): output window columns per row.
REQ-003 Parameter IMAGE_HEIGHT, default `IMAGE_HEIGHT (28): output window rows.
REQ-004 Parameter KERNEL_SIZE, default 3: window edge; padded map is (IMAGE+KERNEL_SIZE-1) square.
REQ-005 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  request to scan one padded map.
REQ-008 Port padded_feature  input  FEATURE_BITWIDTH*PADDED_WIDTH*PADDED_HEIGHT  padded map, element (r,c) at bit offset FEATURE_BITWIDTH*(r*PADDED_WIDTH+c).
REQ-009 Port win_valid  output  1  window on `window` is valid.
REQ-010 Port win_ready  input  1  downstream MAC accepts window.
REQ-011 Port window  output  FEATURE_BITWIDTH*KERNEL_SIZE*KERNEL_SIZE  3x3 window, element (i,j) at offset FEATURE_BITWIDTH*(i*KERNEL_SIZE+j).
REQ-012 Port win_row  output  5  output-pixel row of current window.
REQ-013 Port win_col  output  5  output-pixel column of current window.
REQ-014 Port busy  output  1  high from accepted start until done.
REQ-015 Port done  output  1  one-cycle pulse after last window handshake.

Function
REQ-016 FSM states: IDLE, SCAN, DONE; encoding free.
REQ-017 IDLE with start=1: capture padded_feature into internal map register, set row=col=0, enter SCAN.
REQ-018 start ignored in SCAN and DONE; captured map not altered until next accepted start.
REQ-019 SCAN: win_valid=1; window(i,j)=map(row+i, col+j); win_row=row; win_col=col; all outputs registered.
REQ-020 First window valid on the cycle after the start-accepting edge (latency 1).
REQ-021 Handshake = win_valid & win_ready on a rising edge; window, win_row, win_col held stable while win_valid=1 and win_ready=0.
REQ-022 On handshake with col<IMAGE_WIDTH-1: col+1, same row.
REQ-023 On handshake with col=IMAGE_WIDTH-1 and row<IMAGE_HEIGHT-1: col=0, row+1.
REQ-024 On handshake at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1): enter DONE; win_valid=0 next cycle.
REQ-025 Exactly IMAGE_WIDTH*IMAGE_HEIGHT (784) handshakes per scan, raster order, no skips or repeats.
REQ-026 DONE: done=1 for exactly one cycle, busy=1, then IDLE unconditionally; start during DONE is dropped.
REQ-027 busy=1 in SCAN and DONE, 0 in IDLE.
REQ-028 win_ready asserted while win_valid=0 has no effect.
REQ-029 Back-to-back: start in the cycle after done returns IDLE begins a new scan; minimum gap between scans is one IDLE cycle.

Reset
REQ-030 rst_n low asynchronously forces IDLE, row=col=0, win_valid=0, done=0, busy=0, window=0, win_row=win_col=0.
REQ-031 Reset mid-scan abandons the scan; no done pulse; next scan requires a fresh start.
REQ-032 Captured map register need not be reset.

Structure
REQ-033 PADDED_WIDTH, PADDED_HEIGHT, KERNEL_SIZE, FEATURE_BITWIDTH come from cnn_layer_1_define.vh; no local redefinition of shared constants.
REQ-034 Single module; window extraction is an indexed mux inside it, no sub-module.
REQ-035 Sits directly downstream of padding, upstream of the layer-1 MAC.

Verification (FEATURE_BITWIDTH=8)
REQ-036 Map element (r,c)=(r*30+c) mod 256, start, win_ready=1 -> 784 windows; window(0,0) elements {0,1,2,30,31,32,60,61,62}; last (27,27) element (0,0)=(27*30+27) mod 256=69; done one cycle after last handshake.
REQ-037 win_ready toggled pseudo-randomly (50%) -> identical 784-window sequence; outputs stable during every stall.
REQ-038 padded_feature changed to all 0xFF one cycle after start -> every window still matches the captured map.
REQ-039 start pulsed repeatedly during SCAN and on done cycle -> exactly one scan, one done pulse.
REQ-040 rst_n low after 100 handshakes -> win_valid=0, busy=0 immediately (asynchronous); no done; new start restarts at (0,0).
REQ-041 Row wrap: handshake at (0,27) -> next window (1,0) with element (0,0)=30.

Source files
------------

// File: rtl/conv_window_scanner_pkg.sv
// Shared layer-1 geometry constants and the scanner state encoding.
// Padded map edge is IMAGE + KERNEL - 1 so every output pixel owns a full window.
package conv_window_scanner_pkg;

    localparam int CNN_L1_FEATURE_BITWIDTH = 8;
    localparam int CNN_L1_IMAGE_WIDTH      = 28;
    localparam int CNN_L1_IMAGE_HEIGHT     = 28;
    localparam int CNN_L1_KERNEL_SIZE      = 3;
    localparam int CNN_L1_PADDED_WIDTH     = CNN_L1_IMAGE_WIDTH + CNN_L1_KERNEL_SIZE - 1;
    localparam int CNN_L1_PADDED_HEIGHT    = CNN_L1_IMAGE_HEIGHT + CNN_L1_KERNEL_SIZE - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/conv_window_scanner.sv
// Raster-scans a captured padded feature map and presents one KxK window per
// output pixel over a valid/ready handshake to the layer-1 MAC.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; map register holds last captured map
// SCAN  | window for (row,col) presented; advances on each handshake
// DONE  | one-cycle done pulse after the last handshake, then IDLE
module conv_window_scanner
    import conv_window_scanner_pkg::*;
#(
    parameter int FEATURE_BITWIDTH = CNN_L1_FEATURE_BITWIDTH,
    parameter int IMAGE_WIDTH      = CNN_L1_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT     = CNN_L1_IMAGE_HEIGHT,
    parameter int KERNEL_SIZE      = CNN_L1_KERNEL_SIZE
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic [FEATURE_BITWIDTH*(IMAGE_WIDTH+KERNEL_SIZE-1)*
                  (IMAGE_HEIGHT+KERNEL_SIZE-1)-1:0]                padded_feature,
    output logic                                                   win_valid,
    input  logic                                                   win_ready,
    output logic [FEATURE_BITWIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    window,
    output logic [4:0]                                             win_row,
    output logic [4:0]                                             win_col,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int PADDED_WIDTH  = IMAGE_WIDTH + KERNEL_SIZE - 1;
    localparam int PADDED_HEIGHT = IMAGE_HEIGHT + KERNEL_SIZE - 1;
    localparam int MAP_W         = FEATURE_BITWIDTH * PADDED_WIDTH * PADDED_HEIGHT;
    localparam int WIN_W         = FEATURE_BITWIDTH * KERNEL_SIZE * KERNEL_SIZE;
    localparam logic [4:0] LAST_COL = 5'(IMAGE_WIDTH - 1);
    localparam logic [4:0] LAST_ROW = 5'(IMAGE_HEIGHT - 1);

    scan_state_t        state_q, state_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         col_q, col_d;
    logic               capture;
    logic               load_win;
    logic [MAP_W-1:0]   map_q;
    logic [MAP_W-1:0]   map_src;
    logic [WIN_W-1:0]   window_d;

    function automatic logic [WIN_W-1:0] extract(input logic [MAP_W-1:0] m,
                                                 input logic [4:0]       r,
                                                 input logic [4:0]       c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                w[FEATURE_BITWIDTH*(i*KERNEL_SIZE+j) +: FEATURE_BITWIDTH] =
                    m[FEATURE_BITWIDTH*((int'(r)+i)*PADDED_WIDTH + int'(c)+j) +: FEATURE_BITWIDTH];
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        capture  = 1'b0;
        load_win = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    load_win = 1'b1;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (win_valid && win_ready) begin
                    if (col_q != LAST_COL) begin
                        col_d    = col_q + 5'd1;
                        load_win = 1'b1;
                    end else if (row_q != LAST_ROW) begin
                        col_d    = '0;
                        row_d    = row_q + 5'd1;
                        load_win = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The first window is cut straight from the input so it is ready one cycle after start.
    assign map_src  = capture ? padded_feature : map_q;
    assign window_d = extract(map_src, row_d, col_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            window    <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            win_valid <= (state_d == ST_SCAN);
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            if (load_win) begin
                window  <= window_d;
                win_row <= row_d;
                win_col <= col_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) map_q <= padded_feature;
    end

endmodule

// File: tb/tb_conv_window_scanner.sv
// Scoreboard bench for conv_window_scanner: driver queues expected windows,
// monitor pops and compares on every handshake.
module tb_conv_window_scanner;
    import conv_window_scanner_pkg::*;

    localparam int FB    = 8;
    localparam int IW    = 28;
    localparam int IH    = 28;
    localparam int K     = 3;
    localparam int PW    = IW + K - 1;
    localparam int PH    = IH + K - 1;
    localparam int MAP_W = FB * PW * PH;
    localparam int WIN_W = FB * K * K;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [MAP_W-1:0] padded_feature = '0;
    logic             win_valid;
    logic             win_ready = 1'b0;
    logic [WIN_W-1:0] window;
    logic [4:0]       win_row;
    logic [4:0]       win_col;
    logic             busy;
    logic             done;

    conv_window_scanner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .padded_feature (padded_feature),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .window         (window),
        .win_row        (win_row),
        .win_col        (win_col),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       r;
        logic [4:0]       c;
        logic [WIN_W-1:0] w;
    } exp_t;

    exp_t sb_q[$];
    int   map_m [PH][PW];
    int   n_vec = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   hs_count = 0;
    int   last_hs_cycle = -10;
    int   done_count = 0;
    int   test_id = 0;
    bit   rnd_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [WIN_W+9:0] prev_out;
    logic [WIN_W-1:0] hand_w00;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [MAP_W-1:0] pack_map();
        logic [MAP_W-1:0] p;
        p = '0;
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++)
                p[FB*(r*PW+c) +: FB] = 8'(map_m[r][c]);
        return p;
    endfunction

    function automatic logic [WIN_W-1:0] model_win(input int r, input int c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[FB*(i*K+j) +: FB] = 8'(map_m[r+i][c+j]);
        return w;
    endfunction

    task automatic fill_map(input int mode);
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++)
                map_m[r][c] = (mode == 0) ? ((r*30 + c) % 256) : ((r*7 + c*3 + 5) % 256);
    endtask

    task automatic push_scan();
        exp_t e;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                e.r = 5'(r);
                e.c = 5'(c);
                e.w = model_win(r, c);
                sb_q.push_back(e);
            end
    endtask

    // called at posedge+2; returns at posedge+2 of the cycle after acceptance
    task automatic issue_start();
        push_scan();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("first_valid_latency", win_valid, 1'b1);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("done_within_budget", done, 1'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && win_valid)
                check("stall_outputs_held", {win_row, win_col, window}, prev_out);
            if (win_valid && win_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_window", {win_row, win_col}, 10'h3ff);
                end else begin
                    e = sb_q.pop_front();
                    check("win_row", win_row, e.r);
                    check("win_col", win_col, e.c);
                    check("window", window, e.w);
                    if (test_id == 1) begin
                        if (win_row == 5'd0 && win_col == 5'd0)
                            check("hand_window_0_0", window, hand_w00);
                        if (win_row == 5'd1 && win_col == 5'd0)
                            check("hand_row_wrap_1_0", window[7:0], 8'd30);
                        if (win_row == 5'd27 && win_col == 5'd27)
                            check("hand_last_27_27", window[7:0], 8'd69);
                    end
                end
                hs_count++;
                last_hs_cycle = cycle;
            end
            stall_prev = win_valid && !win_ready;
            prev_out   = {win_row, win_col, window};
            if (done) begin
                done_count++;
                check("done_one_after_last_hs", 32'(cycle - last_hs_cycle), 32'd1);
                check("done_all_windows_seen", 32'(sb_q.size()), 32'd0);
                check("win_valid_low_in_done", win_valid, 1'b0);
                check("busy_high_in_done", busy, 1'b1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int hs0;
        int n;
        hand_w00 = {8'd62, 8'd61, 8'd60, 8'd32, 8'd31, 8'd30, 8'd2, 8'd1, 8'd0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_window", window, '0);
        check("rst_win_row", win_row, 5'd0);
        check("rst_win_col", win_col, 5'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // full scan with ready held high
        test_id = 1;
        fill_map(0);
        padded_feature = pack_map();
        d0 = done_count;
        issue_start();
        wait_done(2000);
        @(posedge clk); #2;
        check("idle_busy_low", busy, 1'b0);
        check("idle_valid_low", win_valid, 1'b0);
        check("scan1_done_pulses", 32'(done_count - d0), 32'd1);

        // back-to-back start in the first IDLE cycle, random backpressure
        test_id = 2;
        rnd_ready = 1'b1;
        d0 = done_count;
        issue_start();
        wait_done(8000);
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        check("scan2_done_pulses", 32'(done_count - d0), 32'd1);

        // input map overwritten right after start must not leak into windows
        test_id = 3;
        d0 = done_count;
        push_scan();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        padded_feature = '1;
        wait_done(2000);
        @(posedge clk); #2;
        check("scan3_done_pulses", 32'(done_count - d0), 32'd1);

        // start pulses during scan and on the done cycle are dropped
        test_id = 4;
        fill_map(1);
        padded_feature = pack_map();
        d0 = done_count;
        issue_start();
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #2;
            n++;
            start = (n % 37 == 5);
        end
        check("scan4_done_seen", done, 1'b1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("scan4_no_restart_valid", win_valid, 1'b0);
        check("scan4_no_restart_busy", busy, 1'b0);
        check("scan4_done_pulses", 32'(done_count - d0), 32'd1);

        // asynchronous reset mid-scan, then a fresh scan from (0,0)
        test_id = 5;
        fill_map(0);
        padded_feature = pack_map();
        d0 = done_count;
        hs0 = hs_count;
        issue_start();
        n = 0;
        while (hs_count - hs0 < 100 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check("reached_100_handshakes", 32'(hs_count - hs0 >= 100), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", win_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_row", win_row, 5'd0);
        sb_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("after_rst_idle_valid", win_valid, 1'b0);
        check("aborted_scan_no_done", 32'(done_count - d0), 32'd0);
        issue_start();
        check("restart_row", win_row, 5'd0);
        check("restart_col", win_col, 5'd0);
        wait_done(2000);
        @(posedge clk); #2;
        check("scan5_done_pulses", 32'(done_count - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
